// File: rtl/commit_trace_buf.sv
// commit_trace_buf: retired-instruction trace FIFO with cycle/instruction/drop counters and HALT tracking
module commit_trace_buf #(
  parameter int DATA_W = 16,
  parameter int REG_W = 3,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        inst,
  input  logic                     reg_wr,
  input  logic [REG_W-1:0]         wr_reg,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     mem_rd,
  input  logic                     mem_wr,
  input  logic [DATA_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     halt,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [2:0]               out_kind,
  output logic [CNT_W-1:0]         out_inum,
  output logic [DATA_W-1:0]        out_pc,
  output logic [REG_W-1:0]         out_reg,
  output logic [DATA_W-1:0]        out_rval,
  output logic [DATA_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_mval,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         inst_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow,
  output logic                     halted,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [AW-1:0] wptr, rptr;
  logic pend;
  logic [CNT_W-1:0] pend_inum;
  logic [DATA_W-1:0] pend_pc;
  logic [2:0] kind, w_kind;
  logic ev, pop, room, push, is_halt, has_reg, has_addr, has_mval;
  logic [2:0] k_mem [DEPTH];
  logic [CNT_W-1:0] i_mem [DEPTH];
  logic [DATA_W-1:0] p_mem [DEPTH];
  logic [REG_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] v_mem [DEPTH];
  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic unused_inst;
  assign unused_inst = ^inst;
  always_comb begin
    kind = (reg_wr && mem_wr) ? 3'd3 : (reg_wr && mem_rd) ? 3'd2 : reg_wr ? 3'd1 :
           halt ? 3'd5 : mem_wr ? 3'd4 : 3'd0;
    ev = commit & ~halted;
    pop = out_valid & out_ready;
    room = (level != LW'(DEPTH)) | pop;
    is_halt = kind == 3'd5;
    // a pending HALT owns the write port; halted blocks any competing event
    push = (pend | ev) & room;
    w_kind = pend ? 3'd5 : kind;
    has_reg = w_kind inside {[3'd1:3'd3]};
    has_addr = w_kind inside {[3'd2:3'd4]};
    has_mval = w_kind inside {3'd3, 3'd4};
  end
  assign out_valid = level != '0;
  assign done = halted & ~pend & (level == '0);
  assign out_kind = out_valid ? k_mem[rptr] : '0;
  assign out_inum = out_valid ? i_mem[rptr] : '0;
  assign out_pc = out_valid ? p_mem[rptr] : '0;
  assign out_reg = out_valid ? r_mem[rptr] : '0;
  assign out_rval = out_valid ? v_mem[rptr] : '0;
  assign out_addr = out_valid ? a_mem[rptr] : '0;
  assign out_mval = out_valid ? m_mem[rptr] : '0;
  always_ff @(posedge clk) begin
    if (push) begin
      k_mem[wptr] <= w_kind;
      i_mem[wptr] <= pend ? pend_inum : inst_count;
      p_mem[wptr] <= pend ? pend_pc : pc;
      r_mem[wptr] <= has_reg ? wr_reg : '0;
      v_mem[wptr] <= has_reg ? wr_data : '0;
      a_mem[wptr] <= has_addr ? mem_addr : '0;
      m_mem[wptr] <= has_mval ? mem_data : '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      cycle_count <= '0;
      inst_count <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
      halted <= 1'b0;
      pend <= 1'b0;
      pend_inum <= '0;
      pend_pc <= '0;
    end else begin
      cycle_count <= cycle_count + 1'b1;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (ev) inst_count <= inst_count + 1'b1;
      if (ev && !room && !is_halt) begin
        drop_count <= (&drop_count) ? drop_count : drop_count + 1'b1;
        overflow <= 1'b1;
      end
      if (ev && is_halt) halted <= 1'b1;
      if (pend && room) pend <= 1'b0;
      else if (ev && is_halt && !room) begin
        pend <= 1'b1;
        pend_inum <= inst_count;
        pend_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_commit_trace_buf.sv
// tb_commit_trace_buf: directed stimulus with a queue scoreboard and reference model of the trace FIFO
module tb_commit_trace_buf;
  localparam int DATA_W = 16, REG_W = 3, DEPTH = 8, CNT_W = 32;
  typedef struct {
    logic [2:0] kind;
    logic [CNT_W-1:0] inum;
    logic [DATA_W-1:0] pc, rval, addr, mval;
    logic [REG_W-1:0] rg;
  } entry_t;

  logic clk = 0, rst = 0, commit = 0, reg_wr = 0, mem_rd = 0, mem_wr = 0, halt = 0, out_ready = 0;
  logic [DATA_W-1:0] pc = 0, inst = 0, wr_data = 0, mem_addr = 0, mem_data = 0;
  logic [REG_W-1:0] wr_reg = 0;
  logic out_valid, overflow, halted, done;
  logic [2:0] out_kind;
  logic [CNT_W-1:0] out_inum, cycle_count, inst_count, drop_count;
  logic [DATA_W-1:0] out_pc, out_rval, out_addr, out_mval;
  logic [REG_W-1:0] out_reg;
  logic [$clog2(DEPTH):0] level;

  commit_trace_buf #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .commit(commit), .pc(pc), .inst(inst), .reg_wr(reg_wr),
    .wr_reg(wr_reg), .wr_data(wr_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt), .out_ready(out_ready),
    .out_valid(out_valid), .out_kind(out_kind), .out_inum(out_inum), .out_pc(out_pc),
    .out_reg(out_reg), .out_rval(out_rval), .out_addr(out_addr), .out_mval(out_mval),
    .level(level), .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .overflow(overflow), .halted(halted), .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  entry_t exp_q[$];
  logic [CNT_W-1:0] m_inst, m_drop, m_cycle, m_pinum;
  logic [DATA_W-1:0] m_ppc;
  logic m_ovf, m_halted, m_pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_inst = 0; m_drop = 0; m_cycle = 0; m_pinum = 0; m_ppc = 0;
    m_ovf = 0; m_halted = 0; m_pend = 0;
  endtask

  task automatic drive(input logic c, input logic [DATA_W-1:0] p, input logic rw, input logic [REG_W-1:0] r,
                       input logic [DATA_W-1:0] wd, input logic mr, input logic mw,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] md, input logic h);
    commit = c; pc = p; inst = p ^ 16'h5a5a; reg_wr = rw; wr_reg = r; wr_data = wd;
    mem_rd = mr; mem_wr = mw; mem_addr = a; mem_data = md; halt = h;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // one clock: check state at negedge, advance model, then cross the rising edge
  task automatic tick();
    entry_t e, h;
    logic [2:0] k;
    logic ev, pop, room;
    int sz;
    @(negedge clk);
    sz = exp_q.size();
    chk("level", 64'(level), 64'(sz));
    chk("out_valid", 64'(out_valid), 64'(sz != 0));
    chk("cycle_count", 64'(cycle_count), 64'(m_cycle));
    chk("inst_count", 64'(inst_count), 64'(m_inst));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("done", 64'(done), 64'(m_halted && !m_pend && sz == 0));
    if (sz != 0) begin
      h = exp_q[0];
      chk("out_kind", 64'(out_kind), 64'(h.kind));
      chk("out_inum", 64'(out_inum), 64'(h.inum));
      chk("out_pc", 64'(out_pc), 64'(h.pc));
      chk("out_reg", 64'(out_reg), 64'(h.rg));
      chk("out_rval", 64'(out_rval), 64'(h.rval));
      chk("out_addr", 64'(out_addr), 64'(h.addr));
      chk("out_mval", 64'(out_mval), 64'(h.mval));
    end
    k = (reg_wr && mem_wr) ? 3'd3 : (reg_wr && mem_rd) ? 3'd2 : reg_wr ? 3'd1 :
        halt ? 3'd5 : mem_wr ? 3'd4 : 3'd0;
    ev = commit && !m_halted;
    pop = (sz != 0) && out_ready;
    room = (sz < DEPTH) || pop;
    if (pop) void'(exp_q.pop_front());
    if (m_pend && room) begin
      e = '{kind: 3'd5, inum: m_pinum, pc: m_ppc, rval: 0, addr: 0, mval: 0, rg: 0};
      exp_q.push_back(e);
      m_pend = 0;
    end else if (ev) begin
      e.kind = k; e.inum = m_inst; e.pc = pc;
      e.rg = (k == 1 || k == 2 || k == 3) ? wr_reg : '0;
      e.rval = (k == 1 || k == 2 || k == 3) ? wr_data : '0;
      e.addr = (k == 2 || k == 3 || k == 4) ? mem_addr : '0;
      e.mval = (k == 3 || k == 4) ? mem_data : '0;
      if (room) exp_q.push_back(e);
      else if (k == 5) begin m_pend = 1; m_pinum = m_inst; m_ppc = pc; end
      else begin m_drop++; m_ovf = 1; end
      if (k == 5) m_halted = 1;
      m_inst++;
    end
    m_cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, 64'(level), 0);
    chk({tag, "_valid"}, 64'(out_valid), 0);
    chk({tag, "_cycle"}, 64'(cycle_count), 0);
    chk({tag, "_inst"}, 64'(inst_count), 0);
    chk({tag, "_drop"}, 64'(drop_count), 0);
    chk({tag, "_flags"}, 64'({overflow, halted, done}), 0);
    chk({tag, "_outs"}, 64'({out_kind, out_inum, out_pc, out_reg}), 0);
    chk({tag, "_outs2"}, 64'({out_rval, out_addr, out_mval}), 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1;
    // three mixed commits drained immediately
    out_ready = 1;
    drive(1, 16'h0000, 1, 3, 16'h1234, 0, 0, 16'h0999, 16'h0777, 0); tick();
    drive(1, 16'h0002, 0, 5, 16'h1111, 0, 1, 16'h0040, 16'hBEEF, 0); tick();
    drive(1, 16'h0004, 0, 2, 16'h2222, 0, 0, 16'h0050, 16'h3333, 0); tick();
    idle(); tick(); tick();
    // overfill with out_ready low, then push+pop at full, then drain
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'(16'h0100 + 2 * i), 1, 3'(i), 16'($urandom), 0, 0, 0, 0, 0);
      tick();
    end
    idle(); tick();
    chk("full_level", 64'(level), DEPTH);
    chk("full_drop", 64'(drop_count), 2);
    out_ready = 1;
    drive(1, 16'h0200, 1, 1, 16'h4321, 1, 0, 16'h0060, 16'h0, 0); tick();
    idle(); out_ready = 0; tick();
    chk("pushpop_level", 64'(level), DEPTH);
    out_ready = 1;
    repeat (DEPTH + 2) tick();
    // full FIFO, HALT pends, one pop lets it in, drain to done
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 16'(16'h0300 + 2 * i), 0, 0, 0, 1, 0, 16'(16'h0080 + i), 0, 0);
      tick();
    end
    drive(1, 16'h0400, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 16'h0402, 1, 2, 16'h0abc, 0, 0, 0, 0, 0); tick();
    idle(); out_ready = 1; tick();
    out_ready = 0; tick();
    chk("halt_enq_level", 64'(level), DEPTH);
    out_ready = 1;
    repeat (DEPTH + 1) tick();
    chk("done_set", 64'(done), 1);
    drive(1, 16'h0500, 1, 1, 16'h1, 0, 0, 0, 0, 0); tick(); tick();
    // STU wins over HALT
    rst = 0; #1; model_reset(); @(posedge clk); #1; rst = 1;
    drive(1, 16'h0600, 1, 4, 16'h5678, 0, 1, 16'h0070, 16'h9abc, 1); tick();
    idle(); tick(); tick();
    chk("stu_not_halted", 64'(halted), 0);
    // reset mid-stream at level 5
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'(16'h0700 + 2 * i), 0, 0, 0, 0, 1, 16'(i), 16'(i * 3), 0);
      tick();
    end
    idle(); tick();
    #2 rst = 0;
    #1 chk_reset_state("async_reset");
    model_reset();
    @(posedge clk); #1; rst = 1;
    tick(); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_trace_buf.md
COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

Interface
REQ-001 Parameter DATA_W, 16, width of PC, instruction, register data, memory address and memory data.
REQ-002 Parameter REG_W, 3, register-select width.
REQ-003 Parameter DEPTH, 8, FIFO entries; power of two, >=2.
REQ-004 Parameter CNT_W, 32, width of cycle, instruction and drop counters.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 commit  in  1  one instruction retires this cycle.
REQ-008 pc, inst  in  DATA_W each  retiring instruction PC and encoding.
REQ-009 reg_wr  in  1;  wr_reg  in  REG_W;  wr_data  in  DATA_W  register-file write.
REQ-010 mem_rd, mem_wr  in  1 each;  mem_addr, mem_data  in  DATA_W  memory access.
REQ-011 halt  in  1  retiring instruction is HALT.
REQ-012 out_ready  in  1  consumer accepts the head entry.
REQ-013 out_valid  out  1  head entry present.
REQ-014 out_kind  out  3  0 NOP/branch, 1 REG, 2 LD, 3 STU, 4 ST, 5 HALT.
REQ-015 out_inum  out  CNT_W;  out_pc, out_rval, out_addr, out_mval  out  DATA_W;  out_reg  out  REG_W  head entry fields.
REQ-016 level  out  clog2(DEPTH)+1  occupied entries.
REQ-017 cycle_count, inst_count, drop_count  out  CNT_W each.
REQ-018 overflow, halted, done  out  1 each  status flags.

Function
REQ-019 Kind classification, priority order: reg_wr&mem_wr -> STU; reg_wr&mem_rd -> LD; reg_wr -> REG; halt -> HALT; mem_wr -> ST; otherwise NOP.
REQ-020 An event is a cycle with commit=1 and halted=0; commit with halted=1 is ignored entirely, with no counter change.
REQ-021 On each event, inst_count increments by 1 and the entry stores out_inum = the inst_count value before the increment, so the first instruction has inum 0.
REQ-022 Entry field capture: out_pc, out_kind and out_inum always. out_reg and out_rval only for REG/LD/STU, else 0. out_addr only for LD/STU/ST, else 0. out_mval only for STU/ST, else 0.
REQ-023 cycle_count increments every clock after reset deassertion and wraps modulo 2^CNT_W.
REQ-024 FIFO storage is registered: an entry written in cycle N is visible on out_* with out_valid=1 from cycle N+1.
REQ-025 A pop occurs when out_valid&out_ready; the next entry appears the following cycle; out_* hold stable while out_valid&!out_ready.
REQ-026 Push and pop in the same cycle are both performed, level is unchanged, and this is permitted when level=DEPTH.
REQ-027 An event with level=DEPTH and no pop is dropped: drop_count increments (saturating at all-ones), overflow sets sticky, and inst_count still increments.
REQ-028 A HALT event is never dropped; if the FIFO is full without a pop, the HALT is held pending and enqueued on the first cycle a slot frees.
REQ-029 halted sets in the cycle after a HALT event is accepted or pended, and stays set until reset.
REQ-030 done = halted & no pending HALT & level=0.
REQ-031 Read and write pointers wrap modulo DEPTH; level ranges 0..DEPTH; out_valid = (level!=0).
REQ-032 out_* are don't-care when out_valid=0 but are driven to 0 after reset.

Reset
REQ-033 While rst=0: all counters 0, level 0, pointers 0, pending HALT cleared, overflow/halted/done 0, out_valid 0, and all out_* 0; this takes effect immediately, including mid-operation.
REQ-034 Contents of the FIFO storage array are not reset and are unobservable until written.

Verification
REQ-035 Reset, then 3 commits (REG r3=0x1234 @pc 0x0000; ST addr 0x0040 val 0xBEEF @0x0002; NOP @0x0004) with out_ready=1 -> entries with inum 0,1,2, kinds 1,4,0, correct fields, each appearing one cycle after its commit.
REQ-036 out_ready=0, 10 REG commits, DEPTH=8 -> level=8, drop_count=2, overflow=1, inst_count=10; then drain -> inum 0..7 in order.
REQ-037 Level=8, simultaneous commit and pop -> level stays 8, no drop, new entry at tail.
REQ-038 Full FIFO, out_ready=0, HALT commit -> halted=1, HALT pending; one pop -> HALT enqueued; drain -> done=1; further commits ignored, inst_count frozen.
REQ-039 reg_wr=1, mem_wr=1, halt=1 together -> kind STU, halted stays 0.
REQ-040 Assert rst low mid-stream with level=5 -> level, counters and flags read 0 immediately; after release, cycle_count counts from 0.
